// File: rtl/udp_box_loader.sv
// Receives box-record packets over a UDP byte stream and presents them frame-synchronously.
// The three banks (staging -> shadow -> active) let a new packet arrive while the current frame keeps a stable bank.
module udp_box_loader #(
    parameter int          N_BOX     = 4,
    parameter int          REC_BYTES = 6,
    parameter logic [7:0]  MAGIC     = 8'hB0
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic [7:0]                     rx_data,
    input  logic                           rx_valid,
    input  logic                           rx_sop,
    input  logic                           rx_eop,
    input  logic                           rx_err,
    input  logic                           vsync,
    output logic [N_BOX*REC_BYTES*8-1:0]   udp_data,
    output logic                           pending,
    output logic                           swap,
    output logic                           pkt_ok,
    output logic [7:0]                     drop_cnt
);
    localparam int TOTB = N_BOX * REC_BYTES;
    localparam int BW   = TOTB * 8;
    localparam int CW   = $clog2(TOTB + 2);
    localparam int NW   = $clog2(N_BOX + 1);
    localparam int JW   = $clog2(REC_BYTES + 1);

    typedef enum logic [1:0] {IDLE, HDR_N, PAYLOAD, DISCARD} state_t;

    state_t          state_q, state_d;
    logic [BW-1:0]   staging_q, staging_d;
    logic [BW-1:0]   shadow_q, active_q;
    logic [NW-1:0]   n_q, n_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [NW-1:0]   box_q, box_d;
    logic [JW-1:0]   bidx_q, bidx_d;
    logic [7:0]      drop_cnt_q, drop_cnt_d;
    logic            pending_q, swap_q, pkt_ok_q, vsync_q;
    logic            accept, rise;
    logic [1:0]      drop_inc;
    logic [8:0]      drop_sum;
    logic [CW-1:0]   total;
    int              slot;

    assign total    = CW'(int'(n_q) * REC_BYTES);
    assign rise     = vsync & ~vsync_q;
    assign drop_sum = {1'b0, drop_cnt_q} + {7'd0, drop_inc};
    assign drop_cnt_d = drop_sum[8] ? 8'hFF : drop_sum[7:0];

    always_comb begin
        state_d   = state_q;
        staging_d = staging_q;
        n_d       = n_q;
        cnt_d     = cnt_q;
        box_d     = box_q;
        bidx_d    = bidx_q;
        drop_inc  = 2'd0;
        accept    = 1'b0;
        slot      = 0;
        if (rx_valid) begin
            if (rx_sop) begin
                // A sop outside IDLE aborts the packet in flight; the new one may itself be dropped too.
                if (state_q != IDLE) drop_inc = drop_inc + 2'd1;
                if (rx_data == MAGIC && !rx_eop) begin
                    staging_d = '0;
                    state_d   = HDR_N;
                end else begin
                    drop_inc = drop_inc + 2'd1;
                    state_d  = rx_eop ? IDLE : DISCARD;
                end
            end else begin
                case (state_q)
                    IDLE: ;
                    HDR_N: begin
                        if (int'(rx_data) >= 1 && int'(rx_data) <= N_BOX && !rx_eop) begin
                            n_d     = NW'(rx_data);
                            cnt_d   = '0;
                            box_d   = '0;
                            bidx_d  = '0;
                            state_d = PAYLOAD;
                        end else begin
                            drop_inc = 2'd1;
                            state_d  = rx_eop ? IDLE : DISCARD;
                        end
                    end
                    PAYLOAD: begin
                        if (cnt_q < total) begin
                            // Big-endian within a record: first byte lands in the top byte of the box.
                            slot = int'(box_q) * REC_BYTES + (REC_BYTES - 1 - int'(bidx_q));
                            staging_d[slot*8 +: 8] = rx_data;
                            cnt_d = cnt_q + CW'(1);
                            if (bidx_q == JW'(REC_BYTES - 1)) begin
                                bidx_d = '0;
                                box_d  = box_q + NW'(1);
                            end else begin
                                bidx_d = bidx_q + JW'(1);
                            end
                            if (rx_eop) begin
                                state_d = IDLE;
                                if (cnt_q == total - CW'(1) && !rx_err) accept = 1'b1;
                                else drop_inc = 2'd1;
                            end
                        end else begin
                            drop_inc = 2'd1;
                            state_d  = rx_eop ? IDLE : DISCARD;
                        end
                    end
                    DISCARD: if (rx_eop) state_d = IDLE;
                    default: state_d = IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            staging_q  <= '0;
            shadow_q   <= '0;
            active_q   <= '0;
            n_q        <= '0;
            cnt_q      <= '0;
            box_q      <= '0;
            bidx_q     <= '0;
            drop_cnt_q <= '0;
            pending_q  <= 1'b0;
            swap_q     <= 1'b0;
            pkt_ok_q   <= 1'b0;
            vsync_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            staging_q  <= staging_d;
            n_q        <= n_d;
            cnt_q      <= cnt_d;
            box_q      <= box_d;
            bidx_q     <= bidx_d;
            drop_cnt_q <= drop_cnt_d;
            vsync_q    <= vsync;
            pkt_ok_q   <= accept;
            swap_q     <= rise & pending_q;
            // Swap uses the pre-edge shadow, so a same-cycle accept stays pending for the next frame.
            if (rise && pending_q) active_q <= shadow_q;
            if (accept) shadow_q <= staging_d;
            pending_q  <= accept | (pending_q & ~rise);
        end
    end

    assign udp_data = active_q;
    assign pending  = pending_q;
    assign swap     = swap_q;
    assign pkt_ok   = pkt_ok_q;
    assign drop_cnt = drop_cnt_q;
endmodule

// File: tb/tb_udp_box_loader.sv
// Directed bench for udp_box_loader with hand-computed bank contents and drop counts.
module tb_udp_box_loader;
    localparam int UW = 192;

    logic          clk, rst;
    logic [7:0]    rx_data;
    logic          rx_valid, rx_sop, rx_eop, rx_err, vsync;
    logic [UW-1:0] udp_data;
    logic          pending, swap, pkt_ok;
    logic [7:0]    drop_cnt;
    int            checks = 0;
    int            errors = 0;

    udp_box_loader dut (
        .clk(clk), .rst(rst), .rx_data(rx_data), .rx_valid(rx_valid), .rx_sop(rx_sop),
        .rx_eop(rx_eop), .rx_err(rx_err), .vsync(vsync), .udp_data(udp_data),
        .pending(pending), .swap(swap), .pkt_ok(pkt_ok), .drop_cnt(drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [UW-1:0] obs, input logic [UW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        @(posedge clk); #1;
    endtask

    task automatic byte_in(input logic [7:0] d, input logic s, input logic e, input logic er);
        rx_data = d; rx_valid = 1'b1; rx_sop = s; rx_eop = e; rx_err = er;
        @(posedge clk); #1;
        rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_err = 1'b0; rx_data = 8'h00;
    endtask

    task automatic send_pkt(input logic [7:0] mg, input logic [7:0] n, input int nb,
                            input logic [7:0] fill, input bit incr, input logic er, input bit vs_last);
        byte_in(mg, 1'b1, 1'b0, 1'b0);
        if (nb == 0) byte_in(n, 1'b0, 1'b1, er);
        else byte_in(n, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < nb; i++) begin
            if (i == 2) idle();
            if (i == nb - 1 && vs_last) vsync = 1'b1;
            byte_in(incr ? fill + 8'(i) : fill, 1'b0, i == nb - 1, (i == nb - 1) ? er : 1'b0);
        end
    endtask

    task automatic vs_rise();
        vsync = 1'b0;
        idle();
        vsync = 1'b1;
        idle();
        vsync = 1'b0;
    endtask

    initial begin
        rst = 1'b1; vsync = 1'b1;
        rx_data = 8'h00; rx_valid = 1'b0; rx_sop = 1'b0; rx_eop = 1'b0; rx_err = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        chk("rst_udp", udp_data, '0);
        chk("rst_pending", UW'(pending), '0);
        chk("rst_pkt_ok", UW'(pkt_ok), '0);
        chk("rst_drop", UW'(drop_cnt), '0);
        idle();
        chk("rst_no_swap_vsync_high", UW'(swap), '0);
        vsync = 1'b0;
        idle();

        // Basic single-box packet, then frame swap.
        send_pkt(8'hB0, 8'd1, 6, 8'h01, 1'b1, 1'b0, 1'b0);
        chk("p1_pkt_ok", UW'(pkt_ok), UW'(1));
        chk("p1_pending", UW'(pending), UW'(1));
        chk("p1_udp_before_vsync", udp_data, '0);
        vs_rise();
        chk("p1_swap", UW'(swap), UW'(1));
        chk("p1_udp", udp_data, {144'd0, 48'h010203040506});
        chk("p1_pending_clr", UW'(pending), '0);
        chk("p1_pkt_ok_pulse", UW'(pkt_ok), '0);
        idle();
        chk("p1_swap_pulse", UW'(swap), '0);

        // Early eop on a two-box packet.
        send_pkt(8'hB0, 8'd2, 11, 8'h77, 1'b0, 1'b0, 1'b0);
        chk("early_drop", UW'(drop_cnt), UW'(1));
        chk("early_pending", UW'(pending), '0);
        chk("early_pkt_ok", UW'(pkt_ok), '0);
        chk("early_udp", udp_data, {144'd0, 48'h010203040506});

        // Second acceptance overwrites shadow; box1 of A must not leak into B.
        send_pkt(8'hB0, 8'd2, 12, 8'hAA, 1'b0, 1'b0, 1'b0);
        send_pkt(8'hB0, 8'd1, 6, 8'h55, 1'b0, 1'b0, 1'b0);
        chk("ab_pending", UW'(pending), UW'(1));
        vs_rise();
        chk("ab_swap", UW'(swap), UW'(1));
        chk("ab_udp", udp_data, {144'd0, 48'h555555555555});
        vs_rise();
        chk("no_pending_no_swap", UW'(swap), '0);
        chk("no_pending_udp", udp_data, {144'd0, 48'h555555555555});

        // Vsync rise coincident with acceptance of C while A pending.
        send_pkt(8'hB0, 8'd1, 6, 8'hA1, 1'b0, 1'b0, 1'b0);
        send_pkt(8'hB0, 8'd1, 6, 8'hC3, 1'b0, 1'b0, 1'b1);
        vsync = 1'b0;
        chk("coinc_swap", UW'(swap), UW'(1));
        chk("coinc_udp_A", udp_data, {144'd0, 48'hA1A1A1A1A1A1});
        chk("coinc_pending", UW'(pending), UW'(1));
        chk("coinc_pkt_ok", UW'(pkt_ok), UW'(1));
        vs_rise();
        chk("coinc_swap2", UW'(swap), UW'(1));
        chk("coinc_udp_C", udp_data, {144'd0, 48'hC3C3C3C3C3C3});
        chk("coinc_pending_clr", UW'(pending), '0);

        // Drop sources (drop_cnt starts at 1 here).
        send_pkt(8'hB1, 8'd1, 6, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("bad_magic", UW'(drop_cnt), UW'(2));
        send_pkt(8'hB0, 8'd0, 3, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("n_zero", UW'(drop_cnt), UW'(3));
        send_pkt(8'hB0, 8'd5, 6, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("n_too_big", UW'(drop_cnt), UW'(4));
        send_pkt(8'hB0, 8'd1, 6, 8'h00, 1'b0, 1'b1, 1'b0);
        chk("rx_err", UW'(drop_cnt), UW'(5));
        chk("rx_err_pending", UW'(pending), '0);
        byte_in(8'hB0, 1'b1, 1'b0, 1'b0);
        byte_in(8'd1, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) byte_in(8'hEE, 1'b0, 1'b0, 1'b0);
        send_pkt(8'hB0, 8'd1, 6, 8'h3C, 1'b1, 1'b0, 1'b0);
        chk("sop_abort_drop", UW'(drop_cnt), UW'(6));
        chk("sop_restart_ok", UW'(pkt_ok), UW'(1));
        send_pkt(8'hB0, 8'd1, 7, 8'h99, 1'b0, 1'b0, 1'b0);
        chk("late_eop", UW'(drop_cnt), UW'(7));
        vs_rise();
        chk("restart_udp", udp_data, {144'd0, 48'h3C3D3E3F4041});
        for (int i = 0; i < 300; i++) byte_in(8'h00, 1'b1, 1'b1, 1'b0);
        chk("drop_sat", UW'(drop_cnt), UW'(255));

        // Async reset mid-payload, then a full four-box packet.
        byte_in(8'hB0, 1'b1, 1'b0, 1'b0);
        byte_in(8'd2, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 3; i++) byte_in(8'h44, 1'b0, 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_udp", udp_data, '0);
        chk("async_rst_drop", UW'(drop_cnt), '0);
        idle();
        rst = 1'b0;
        idle();
        send_pkt(8'hB0, 8'd4, 24, 8'h10, 1'b1, 1'b0, 1'b0);
        chk("post_rst_pkt_ok", UW'(pkt_ok), UW'(1));
        chk("post_rst_drop", UW'(drop_cnt), '0);
        vs_rise();
        chk("post_rst_udp", udp_data, {48'h222324252627, 48'h1C1D1E1F2021,
                                       48'h161718191A1B, 48'h101112131415});

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/udp_box_loader.md
UDP_BOX_LOADER -- requirements
Module: udp_box_loader

Interface
REQ-001 SHALL have parameter N_BOX, default 4: number of box records held.
REQ-002 SHALL have parameter REC_BYTES, default 6: bytes per packed box record (48 bits, 720p packing).
REQ-003 SHALL have parameter MAGIC, default 8'hB0: required first payload byte.
REQ-004 SHALL have ports:
  clk  input  1  single clock domain.
  rst  input  1  asynchronous reset, active-high.
  rx_data  input  8  UDP payload byte.
  rx_valid  input  1  rx_data qualifier.
  rx_sop  input  1  first byte of packet; valid only with rx_valid.
  rx_eop  input  1  last byte of packet; valid only with rx_valid.
  rx_err  input  1  packet error flag; sampled with the rx_eop byte.
  vsync  input  1  video frame sync level.
  udp_data  output  N_BOX*REC_BYTES*8  active record bank; box i occupies bits [(i+1)*48-1:i*48].
  pending  output  1  a committed bank is waiting for vsync.
  swap  output  1  one-cycle pulse when udp_data updates.
  pkt_ok  output  1  one-cycle pulse on accepted packet.
  drop_cnt  output  8  count of dropped packets, saturating at 255.

Function
REQ-005 SHALL use packet format: byte0 = MAGIC, byte1 = n (box count), then n*REC_BYTES record bytes.
REQ-006 SHALL pack each record big-endian: the first record byte goes to bits 47:40 of box k, where k = record index in arrival order.
REQ-007 SHALL hold three banks: staging (written during receive), shadow (last accepted), and active (drives udp_data).
REQ-008 SHALL implement FSM states IDLE, HDR_N, PAYLOAD, DISCARD.
REQ-009 In IDLE, rx_valid & rx_sop & rx_data==MAGIC SHALL clear staging to zero and go to HDR_N; other bytes SHALL be ignored.
REQ-010 In IDLE, a sop byte with a wrong magic SHALL go to DISCARD, or count a drop directly if rx_eop is also set.
REQ-011 In HDR_N, an accepted byte with 1<=n<=N_BOX and no eop SHALL latch n, zero the byte counter and go to PAYLOAD; otherwise the packet SHALL be dropped (go to DISCARD, or go to IDLE if eop).
REQ-012 In PAYLOAD, each valid byte SHALL be written to staging and SHALL increment the byte counter.
REQ-013 The packet SHALL be accepted only when rx_eop arrives on byte number n*REC_BYTES of the payload with rx_err=0.
REQ-014 An early eop, a late eop (excess bytes route to DISCARD), or rx_err=1 SHALL drop the packet.
REQ-015 DISCARD SHALL ignore bytes until rx_eop, then go to IDLE.
REQ-016 A drop SHALL increment drop_cnt exactly once per packet, in the cycle the drop decision is made.
REQ-017 rx_sop arriving in HDR_N, PAYLOAD or DISCARD SHALL count the aborted packet as dropped and restart per REQ-009/010 in the same cycle.
REQ-018 Acceptance SHALL copy staging to shadow on the next clock edge, pulse pkt_ok, and set pending.
REQ-019 Boxes with index >= n SHALL be zero in shadow.
REQ-020 A new acceptance while pending=1 SHALL overwrite shadow; only the latest accepted bank is kept.
REQ-021 vsync rise SHALL be detected as vsync & ~vsync_q, with vsync_q registered.
REQ-022 On a vsync rise with pending=1, the block SHALL copy shadow to active, pulse swap one cycle later with udp_data updated in that same cycle, and clear pending.
REQ-023 A vsync rise with pending=0 SHALL leave active unchanged and SHALL NOT pulse swap.
REQ-024 When acceptance and a vsync rise fall in the same cycle, the block SHALL swap the pre-existing shadow (if pending) and leave pending=1 holding the new shadow.
REQ-025 Latency from the accepted eop byte to pending=1 SHALL be 1 cycle.
REQ-026 Latency from the vsync rise to the udp_data update SHALL be 1 cycle.
REQ-027 Cycles with rx_valid=0 SHALL NOT change the FSM or the byte counter.

Reset
REQ-028 rst SHALL asynchronously force: FSM to IDLE; all banks to zero; udp_data=0; pending=0; swap=0; pkt_ok=0; drop_cnt=0; vsync_q=1 (no spurious swap if vsync is high at release).
REQ-029 A reset mid-packet SHALL discard the partial packet without counting a drop.

Verification
REQ-030 Send magic B0, n=1, bytes 01..06, eop, rx_err=0, then a vsync rise -> pkt_ok pulse, pending=1, then swap, udp_data[47:0]=48'h010203040506, upper boxes=0, pending=0.
REQ-031 Send n=2 with only 11 record bytes (early eop) -> drop_cnt=1, pending=0, udp_data unchanged.
REQ-032 Accept packet A (box0=all 0xAA), then packet B (box0=all 0x55), then a vsync rise -> one swap, udp_data box0=48'h555555555555.
REQ-033 Assert a vsync rise in the same cycle packet C commits while packet A is pending -> swap shows A; pending stays 1; the next vsync rise shows C.
REQ-034 Apply bad magic, n=0, n=N_BOX+1, rx_err=1, and a sop mid-payload, each once -> drop_cnt=5 (plus the restarted packet's outcome); then 300 bad packets -> drop_cnt=255.
REQ-035 Assert rst during PAYLOAD, then send a valid packet -> drop_cnt=0 and the packet is accepted normally.
